// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM state type, widths and saturation limits for fc_compute
package fc_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, INIT, MAC, STORE, OUT} fc_state_e;
  localparam int WORD_LEN = 32;
  localparam int ACC_LEN = 64;
  localparam logic signed [ACC_LEN-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_LEN-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;
endpackage

// File: rtl/fc_mac_unit.sv
// fc_mac_unit: registered signed 32x32 multiply-accumulate with saturating 32-bit output
// Ports: clk, rst_n (async active-low); init loads sign-extended bias;
//        acc_en adds a*b; sat is the accumulator clamped to signed 32-bit.
module fc_mac_unit
  import fc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init,
  input  logic                       acc_en,
  input  logic signed [WORD_LEN-1:0] bias,
  input  logic signed [WORD_LEN-1:0] a,
  input  logic signed [WORD_LEN-1:0] b,
  output logic signed [WORD_LEN-1:0] sat
);
  logic signed [ACC_LEN-1:0] acc_q, acc_d, prod;
  always_comb begin
    prod = ACC_LEN'(a) * ACC_LEN'(b);
    acc_d = init ? ACC_LEN'(bias) : acc_en ? acc_q + prod : acc_q;
    sat = acc_q > SAT_MAX ? SAT_MAX[WORD_LEN-1:0] :
          acc_q < SAT_MIN ? SAT_MIN[WORD_LEN-1:0] : acc_q[WORD_LEN-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/fc_compute.sv
// fc_compute: fully-connected layer, result[b][o] = bias[o] + sum_f data[b][f]*weight[f][o]
// Ports: clk, rst_n (async active-low); NrcFc_data/weight/bias + *_valid operand
//        levels (captured on 0->1); FcNwc_result/_valid held until NwcFc_result_ready;
//        FcNc_busy high outside IDLE/COLLECT; FcNc_done pulses after acceptance.
// Build option: FC_RELU_EN clamps negative stored elements to 0.
module fc_compute
  import fc_pkg::*;
#(
  parameter int batch_size   = 1,
  parameter int feature_size = 1,
  parameter int bias_size    = 1,
  parameter int word_len     = 32
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [batch_size-1:0][feature_size-1:0][word_len-1:0] NrcFc_data,
  input  logic [feature_size-1:0][bias_size-1:0][word_len-1:0]  NrcFc_weight,
  input  logic [bias_size-1:0][word_len-1:0]                    NrcFc_bias,
  input  logic                                                 NrcFc_data_valid,
  input  logic                                                 NrcFc_weight_valid,
  input  logic                                                 NrcFc_bias_valid,
  output logic [batch_size-1:0][bias_size-1:0][word_len-1:0]    FcNwc_result,
  output logic                                                 FcNwc_result_valid,
  input  logic                                                 NwcFc_result_ready,
  output logic                                                 FcNc_busy,
  output logic                                                 FcNc_done
);
  localparam int BW = batch_size > 1 ? $clog2(batch_size) : 1;
  localparam int OW = bias_size > 1 ? $clog2(bias_size) : 1;
  localparam int FW = feature_size > 1 ? $clog2(feature_size) : 1;
  fc_state_e state_q, state_d;
  logic [2:0] vld, vld_q, flag_q, flag_d, cap;
  logic [batch_size-1:0][feature_size-1:0][word_len-1:0] data_q, data_d;
  logic [feature_size-1:0][bias_size-1:0][word_len-1:0] weight_q, weight_d;
  logic [bias_size-1:0][word_len-1:0] bias_q, bias_d;
  logic [batch_size-1:0][bias_size-1:0][word_len-1:0] result_q, result_d;
  logic [BW-1:0] b_q, b_d;
  logic [OW-1:0] o_q, o_d;
  logic [FW-1:0] f_q, f_d;
  logic done_q, done_d, b_last, o_last, f_last;
  logic [word_len-1:0] sat, elem;
  assign vld = {NrcFc_data_valid, NrcFc_weight_valid, NrcFc_bias_valid};
  assign b_last = b_q == BW'(batch_size - 1);
  assign o_last = o_q == OW'(bias_size - 1);
  assign f_last = f_q == FW'(feature_size - 1);
`ifdef FC_RELU_EN
  assign elem = sat[word_len-1] ? '0 : sat;
`else
  assign elem = sat;
`endif
  fc_mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (state_q == INIT),
    .acc_en(state_q == MAC),
    .bias  (bias_q[o_q]),
    .a     (data_q[b_q][f_q]),
    .b     (weight_q[f_q][o_q]),
    .sat   (sat)
  );
  // Operands are only accepted on a rising valid while not computing or presenting.
  always_comb begin
    cap = vld & ~vld_q & {3{state_q == IDLE || state_q == COLLECT}};
    flag_d = flag_q | cap;
    data_d = cap[2] ? NrcFc_data : data_q;
    weight_d = cap[1] ? NrcFc_weight : weight_q;
    bias_d = cap[0] ? NrcFc_bias : bias_q;
    state_d = state_q;
    b_d = b_q;
    o_d = o_q;
    f_d = f_q;
    result_d = result_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: state_d = |cap ? COLLECT : IDLE;
      COLLECT: state_d = &flag_d ? INIT : COLLECT;
      INIT: state_d = MAC;
      MAC: begin
        f_d = f_last ? '0 : f_q + 1'b1;
        state_d = f_last ? STORE : MAC;
      end
      STORE: begin
        result_d[b_q][o_q] = elem;
        o_d = o_last ? '0 : o_q + 1'b1;
        b_d = !o_last ? b_q : b_last ? '0 : b_q + 1'b1;
        state_d = o_last && b_last ? OUT : INIT;
      end
      OUT: if (NwcFc_result_ready) begin
        state_d = IDLE;
        done_d = 1'b1;
        flag_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q <= '0;
      flag_q <= '0;
      data_q <= '0;
      weight_q <= '0;
      bias_q <= '0;
      result_q <= '0;
      b_q <= '0;
      o_q <= '0;
      f_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q <= vld;
      flag_q <= flag_d;
      data_q <= data_d;
      weight_q <= weight_d;
      bias_q <= bias_d;
      result_q <= result_d;
      b_q <= b_d;
      o_q <= o_d;
      f_q <= f_d;
      done_q <= done_d;
    end
  assign FcNwc_result = result_q;
  assign FcNwc_result_valid = state_q == OUT;
  assign FcNc_busy = !(state_q == IDLE || state_q == COLLECT);
  assign FcNc_done = done_q;
endmodule

// File: tb/tb_fc_compute.sv
// tb_fc_compute: scoreboard bench for fc_compute on a 1x2x1 and a 2x4x3 instance
module tb_fc_compute;
`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  logic [0:0][1:0][31:0] s_data;
  logic [1:0][0:0][31:0] s_weight;
  logic [0:0][31:0] s_bias;
  logic [0:0][0:0][31:0] s_res;
  logic s_dv = 0, s_wv = 0, s_bv = 0, s_rdy = 0, s_valid, s_busy, s_done;
  logic [1:0][3:0][31:0] g_data;
  logic [3:0][2:0][31:0] g_weight;
  logic [2:0][31:0] g_bias;
  logic [1:0][2:0][31:0] g_res;
  logic g_dv = 0, g_wv = 0, g_bv = 0, g_rdy = 0, g_valid, g_busy, g_done;
  logic [31:0] qs[$];
  logic [191:0] qg[$];
  int gx[2][4], gw[4][3], gb[3];
  fc_compute #(.batch_size(1), .feature_size(2), .bias_size(1), .word_len(32)) u_s (
    .clk(clk), .rst_n(rst_n), .NrcFc_data(s_data), .NrcFc_weight(s_weight), .NrcFc_bias(s_bias),
    .NrcFc_data_valid(s_dv), .NrcFc_weight_valid(s_wv), .NrcFc_bias_valid(s_bv),
    .FcNwc_result(s_res), .FcNwc_result_valid(s_valid), .NwcFc_result_ready(s_rdy),
    .FcNc_busy(s_busy), .FcNc_done(s_done));
  fc_compute #(.batch_size(2), .feature_size(4), .bias_size(3), .word_len(32)) u_g (
    .clk(clk), .rst_n(rst_n), .NrcFc_data(g_data), .NrcFc_weight(g_weight), .NrcFc_bias(g_bias),
    .NrcFc_data_valid(g_dv), .NrcFc_weight_valid(g_wv), .NrcFc_bias_valid(g_bv),
    .FcNwc_result(g_res), .FcNwc_result_valid(g_valid), .NwcFc_result_ready(g_rdy),
    .FcNc_busy(g_busy), .FcNc_done(g_done));
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [191:0] model_g();
    logic [191:0] r;
    longint a;
    r = '0;
    for (int b = 0; b < 2; b++)
      for (int o = 0; o < 3; o++) begin
        a = gb[o];
        for (int f = 0; f < 4; f++) a += longint'(gx[b][f]) * longint'(gw[f][o]);
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (a < -64'sh8000_0000) a = -64'sh8000_0000;
        if (RELU && a < 0) a = 0;
        r[(b*3+o)*32 +: 32] = a[31:0];
      end
    return r;
  endfunction
  task automatic g_load(input int v);
    for (int b = 0; b < 2; b++) for (int f = 0; f < 4; f++) gx[b][f] = v == 0 ? b*4+f+1 : b ? -(f+2) : f*3-1;
    for (int f = 0; f < 4; f++) for (int o = 0; o < 3; o++) gw[f][o] = v == 0 ? f+o+1 : o*2-f+(o==2 ? 4-o*2 : 0);
    for (int o = 0; o < 3; o++) gb[o] = v == 0 ? o : 100*o-50;
    if (v == 1) begin
      gx[1][3] = 32'h4000_0000;
      gw[3][2] = 4;
    end
    for (int b = 0; b < 2; b++) for (int f = 0; f < 4; f++) g_data[b][f] = gx[b][f];
    for (int f = 0; f < 4; f++) for (int o = 0; o < 3; o++) g_weight[f][o] = gw[f][o];
    for (int o = 0; o < 3; o++) g_bias[o] = gb[o];
  endtask
  task automatic s_accept();
    s_rdy = 1;
    tick();
    s_rdy = 0;
    chk("s_done_pulse", {s_done, s_valid}, 2'b10);
    tick();
    chk("s_back_idle", {s_done, s_valid, s_busy}, 3'b000);
  endtask
  task automatic s_finish(input int hold, input logic [31:0] exp);
    int t;
    for (int i = 0; i < 20 && !s_busy; i++) tick();
    chk("s_start", s_busy, 1);
    t = cyc;
    for (int i = 0; i < 20 && !s_valid; i++) tick();
    chk("s_latency", cyc - t, 4);
    s_dv = 0; s_wv = 0; s_bv = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("s_hold", {s_valid, s_done, s_res}, {2'b10, exp});
    end
    s_accept();
  endtask
  task automatic s_run(input logic [31:0] x0, x1, w0, w1, bi, exp);
    s_data[0][0] = x0; s_data[0][1] = x1;
    s_weight[0][0] = w0; s_weight[1][0] = w1;
    s_bias[0] = bi;
    qs.push_back(exp);
    s_dv = 1; s_wv = 1; s_bv = 1;
    s_finish(0, exp);
  endtask
  initial forever begin : mon_s
    logic seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (s_valid && !seen) begin
        seen = 1;
        if (qs.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL s_scoreboard: unexpected result %h", s_res);
        end else chk("s_result", s_res, qs.pop_front());
      end
      if (!s_valid) seen = 0;
    end
  end
  initial forever begin : mon_g
    logic seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (g_valid && !seen) begin
        seen = 1;
        if (qg.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL g_scoreboard: unexpected result %h", g_res);
        end else chk("g_result", g_res, qg.pop_front());
      end
      if (!g_valid) seen = 0;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic early;
    int t;
    s_data = '0; s_weight = '0; s_bias = '0;
    g_data = '0; g_weight = '0; g_bias = '0;
    #12;
    chk("s_reset", {s_res, s_valid, s_busy, s_done}, 0);
    chk("g_reset", {g_res, g_valid, g_busy, g_done}, 0);
    #10 rst_n = 1;
    tick();
    s_run(3, 4, 5, 6, 7, 46);
    s_run(32'hFFFF_FFFE, 0, 3, 0, 1, RELU ? 32'h0 : 32'hFFFF_FFFB);
    s_run(32'h7FFF_FFFF, 0, 2, 0, 0, 32'h7FFF_FFFF);
    s_run(32'h8000_0000, 0, 2, 0, 0, RELU ? 32'h0 : 32'h8000_0000);
    s_data[0][0] = 1; s_data[0][1] = 2;
    s_weight[0][0] = 3; s_weight[1][0] = 4;
    s_bias[0] = 5;
    qs.push_back(16);
    tick();
    s_bv = 1;
    early = 0;
    repeat (5) begin tick(); early |= s_busy; end
    s_wv = 1;
    repeat (4) begin tick(); early |= s_busy; end
    s_dv = 1;
    chk("s_stagger_early", early, 0);
    tick();
    chk("s_stagger_init", s_busy, 1);
    s_finish(10, 16);
    g_load(0);
    g_dv = 1; g_wv = 1; g_bv = 1;
    for (int i = 0; i < 20 && !g_busy; i++) tick();
    chk("g_start", g_busy, 1);
    repeat (8) tick();
    #1 rst_n = 0;
    #1 chk("g_rst_mid_mac", {g_res, g_valid, g_busy, g_done}, 0);
    g_dv = 0; g_wv = 0; g_bv = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("g_post_rst", {g_res, g_valid, g_busy, g_done}, 0);
    g_load(1);
    qg.push_back(model_g());
    g_dv = 1; g_wv = 1; g_bv = 1;
    for (int i = 0; i < 20 && !g_busy; i++) tick();
    chk("g_start2", g_busy, 1);
    t = cyc;
    repeat (3) tick();
    g_dv = 0;
    g_data = '1;
    tick();
    g_dv = 1;
    for (int i = 0; i < 100 && !g_valid; i++) tick();
    chk("g_latency", cyc - t, 36);
    g_dv = 0; g_wv = 0; g_bv = 0;
    g_rdy = 1;
    tick();
    g_rdy = 0;
    chk("g_done_pulse", {g_done, g_valid}, 2'b10);
    tick();
    chk("g_back_idle", {g_done, g_valid, g_busy}, 3'b000);
    repeat (3) tick();
    chk("s_sb_drained", qs.size(), 0);
    chk("g_sb_drained", qg.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fc_compute.md
FC_COMPUTE -- requirements
Module: fc_compute

Interface
REQ-001 SHALL have parameter batch_size, default 1, number of input rows (B).
REQ-002 SHALL have parameter feature_size, default 1, input features per row (F).
REQ-003 SHALL have parameter bias_size, default 1, output neurons (O).
REQ-004 SHALL have parameter word_len, default 32, element width; only 32 is supported.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port NrcFc_data  input  [B][F][32]  input activations, signed.
REQ-008 SHALL have port NrcFc_weight  input  [F][O][32]  weights, signed.
REQ-009 SHALL have port NrcFc_bias  input  [O][32]  biases, signed.
REQ-010 SHALL have ports NrcFc_data_valid, NrcFc_weight_valid, NrcFc_bias_valid  input  1 each  operand-ready levels from the read controller.
REQ-011 SHALL have port FcNwc_result  output  [B][O][32]  result matrix, signed.
REQ-012 SHALL have port FcNwc_result_valid  output  1  result held and valid.
REQ-013 SHALL have port NwcFc_result_ready  input  1  downstream accepts result.
REQ-014 SHALL have ports FcNc_busy  output  1  (high outside IDLE/COLLECT), and FcNc_done  output  1  (one-cycle pulse on result acceptance).

Function
REQ-015 SHALL compute result[b][o] = bias[o] + sum over f of data[b][f]*weight[f][o].
REQ-016 SHALL capture each operand group into internal registers on the cycle its valid rises 0->1, setting a sticky flag; a held-high valid does not recapture.
REQ-017 SHALL use states IDLE, COLLECT, INIT, MAC, STORE, OUT.
REQ-018 SHALL move IDLE->COLLECT on the first captured valid, and COLLECT->INIT in the cycle after all three flags are set, in any arrival order; simultaneous rises are all captured.
REQ-019 SHALL iterate b outer, o middle, f inner; INIT loads a 64-bit accumulator with sign-extended bias[o] (1 cycle); MAC adds one signed 64-bit product per cycle (F cycles); STORE writes the saturated element (1 cycle).
REQ-020 SHALL saturate each stored element to signed 32-bit range (0x7FFFFFFF / 0x80000000).
REQ-021 SHALL enter OUT after the last STORE, asserting FcNwc_result_valid; total latency from INIT entry to result_valid high SHALL be B*O*(F+2) cycles.
REQ-022 SHALL hold FcNwc_result and result_valid stable while ready is low; on valid&&ready it SHALL drop valid, pulse FcNc_done, clear flags and return to IDLE next cycle.
REQ-023 SHALL ignore valid rises while busy; a rise during OUT is also ignored (operands are re-presented by a later rise).
REQ-024 SHALL keep counters wrap-free: b, o, f counters reset to 0 at each level's last index.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-MAC, force IDLE and clear result, accumulator, counters, flags, operand registers and all outputs to 0, asynchronously.

Configuration
REQ-026 SHALL, with macro FC_RELU_EN defined, clamp negative stored elements to 0 after saturation; without it, store the saturated signed value unchanged; latency identical in both.

Structure
REQ-027 SHALL take the state enum, WORD_LEN=32, ACC_LEN=64 and the saturation limits from shared package fc_pkg.
REQ-028 SHALL instantiate one sub-module fc_mac_unit (registered signed 32x32 multiply-accumulate with init/accumulate controls and saturating output); the FSM and operand storage stay in fc_compute.

Verification
REQ-029 SHALL test B=1,F=2,O=1, x=[3,4], W=[5,6], b=7 -> result 46, result_valid 4 cycles after INIT.
REQ-030 SHALL test x=[-2], W=[3], b=1 -> -5; with FC_RELU_EN -> 0.
REQ-031 SHALL test x=[0x7FFFFFFF], W=[2], b=0 -> 0x7FFFFFFF; x=[0x80000000], W=[2] -> 0x80000000.
REQ-032 SHALL test valids rising bias, weight, data on cycles 0, 5, 9 -> INIT entered cycle 10, no earlier.
REQ-033 SHALL test ready held low 10 cycles in OUT -> result and valid unchanged; ready high -> done pulse 1 cycle, IDLE next.
REQ-034 SHALL test rst_n low during MAC of B=2,F=4,O=3 -> all outputs 0 same cycle; fresh operands afterwards produce correct results.
